// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: freezes on memory waits, flushes on taken control
// transfers, inserts one bubble per load-use, and counts bubbles and stall cycles.
module hazard_stall_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  id_sr1,
    input  logic [2:0]  id_sr2,
    input  logic        id_uses_sr1,
    input  logic        id_uses_sr2,
    input  logic        ex_mem_read,
    input  logic [2:0]  ex_dest,
    input  logic        mem_br_taken,
    input  logic        imem_read,
    input  logic        imem_resp,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic        dmem_resp,
    output logic        load_pc,
    output logic        load_IF_ID,
    output logic        load_ID_EX,
    output logic        load_EX_MEM,
    output logic        load_MEM_WB,
    output logic        insert_nop,
    output logic        flush_IF_ID,
    output logic        flush_ID_EX,
    output logic        flush_EX_MEM,
    output logic [15:0] bubble_count,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN,
        MEM_STALL,
        FLUSH_SHADOW
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] bubble_q, bubble_d;
    logic [15:0] stall_q, stall_d;
    logic        mem_wait;
    logic        load_use;

    assign mem_wait = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp);
    assign load_use = ex_mem_read & ((id_uses_sr1 & (id_sr1 == ex_dest)) |
                                     (id_uses_sr2 & (id_sr2 == ex_dest)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            bubble_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
            stall_q  <= stall_d;
        end
    end

    always_comb begin
        state_d      = RUN;
        bubble_d     = bubble_q;
        stall_d      = stall_q;
        load_pc      = 1'b1;
        load_IF_ID   = 1'b1;
        load_ID_EX   = 1'b1;
        load_EX_MEM  = 1'b1;
        load_MEM_WB  = 1'b1;
        insert_nop   = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;

        // Reset gates the enables directly so they drop without waiting for a clock.
        if (reset) begin
            load_pc     = 1'b0;
            load_IF_ID  = 1'b0;
            load_ID_EX  = 1'b0;
            load_EX_MEM = 1'b0;
            load_MEM_WB = 1'b0;
        end else if (mem_wait) begin
            load_pc     = 1'b0;
            load_IF_ID  = 1'b0;
            load_ID_EX  = 1'b0;
            load_EX_MEM = 1'b0;
            load_MEM_WB = 1'b0;
            state_d     = MEM_STALL;
            stall_d     = (stall_q == '1) ? stall_q : stall_q + 16'd1;
        end else if (mem_br_taken) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            state_d      = FLUSH_SHADOW;
        end else if (load_use && (state_q != FLUSH_SHADOW)) begin
            // ID holds a flushed NOP in the shadow cycle, so a match there is spurious.
            load_pc    = 1'b0;
            load_IF_ID = 1'b0;
            insert_nop = 1'b1;
            bubble_d   = (bubble_q == '1) ? bubble_q : bubble_q + 16'd1;
        end
    end

    assign bubble_count = bubble_q;
    assign stall_count  = stall_q;

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 clk  input  1  Pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  Asynchronous, active-high reset.
REQ-003 id_sr1, id_sr2  input  3 each  Source register numbers of the instruction in ID.
REQ-004 id_uses_sr1, id_uses_sr2  input  1 each  Qualify id_sr1 and id_sr2 as real reads.
REQ-005 ex_mem_read  input  1  Instruction in EX is a load (LDR/LDB/LDI).
REQ-006 ex_dest  input  3  Destination register of the instruction in EX.
REQ-007 mem_br_taken  input  1  Control transfer resolved taken in MEM.
REQ-008 imem_read, imem_resp  input  1 each  Instruction-memory request and response.
REQ-009 dmem_read, dmem_write, dmem_resp  input  1 each  Data-memory requests and response.
REQ-010 load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB  output  1 each  Register enables.
REQ-011 insert_nop  output  1  Select the NOP control word into ID/EX in place of the decoded word.
REQ-012 flush_IF_ID, flush_ID_EX, flush_EX_MEM  output  1 each  Replace stage contents with NOP on the next edge.
REQ-013 bubble_count  output  16  Saturating count of inserted load-use bubbles.
REQ-014 stall_count  output  16  Saturating count of memory-stall cycles.

Function
REQ-015 FSM states: RUN, MEM_STALL, FLUSH_SHADOW; the state register and both counters are the only flops.
REQ-016 mem_wait = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp).
REQ-017 load_use = ex_mem_read & ((id_uses_sr1 & id_sr1==ex_dest) | (id_uses_sr2 & id_sr2==ex_dest)).
REQ-018 Priority: mem_wait > mem_br_taken > load_use.
REQ-019 mem_wait=1: all load_* = 0; insert_nop = 0; all flush_* = 0; next state MEM_STALL; stall_count += 1.
REQ-020 mem_wait=0 & mem_br_taken=1: all load_* = 1; flush_IF_ID = flush_ID_EX = flush_EX_MEM = 1; insert_nop = 0; next state FLUSH_SHADOW.
REQ-021 load_use=1 & not suppressed & no higher priority: load_pc = load_IF_ID = 0; load_ID_EX = load_EX_MEM = load_MEM_WB = 1; insert_nop = 1; bubble_count += 1; next state RUN.
REQ-022 In FLUSH_SHADOW, load_use is suppressed for that one cycle because ID holds a flushed NOP; mem_wait and mem_br_taken are still honoured.
REQ-023 No hazard present: all load_* = 1, flushes and insert_nop = 0, next state RUN.
REQ-024 MEM_STALL exits to the state selected by REQ-020 to REQ-023 in the first cycle with mem_wait=0.
REQ-025 A branch or load-use pending during a stall takes effect in the response cycle, not before.
REQ-026 Outputs are combinational from the current inputs and state; load-use and flush latency are zero cycles; a load-use inserts exactly one bubble.
REQ-027 Counters saturate at 16'hFFFF and never wrap.
REQ-028 insert_nop and any flush_* are never asserted in the same cycle as a frozen pipeline.

Reset
REQ-029 While reset=1, independent of clk: state = RUN; bubble_count = stall_count = 0; all load_*, flush_*, and insert_nop = 0.
REQ-030 Reset asserted mid-stall or mid-flush abandons the operation with no pending effect after release.
REQ-031 First cycle after release follows REQ-016 to REQ-023 normally.

Verification
REQ-032 Load-use: ex_mem_read=1, ex_dest=3, id_uses_sr1=1, id_sr1=3 -> one cycle with load_pc=0, load_IF_ID=0, insert_nop=1; bubble_count 0->1; next cycle (EX holds NOP) all loads 1.
REQ-033 Memory stall: dmem_read=1, dmem_resp=0 for 3 cycles, then 1 -> all load_*=0 for 3 cycles, stall_count=3; all load_*=1 in the response cycle.
REQ-034 Branch flush: mem_br_taken=1 -> all three flush_*=1 for one cycle; the following cycle, with a matching load_use pattern, gives insert_nop=0 (FLUSH_SHADOW).
REQ-035 Simultaneous: mem_br_taken=1 with imem_read=1, imem_resp=0 for 2 cycles -> no flush while frozen; flush_*=1 in the cycle imem_resp=1.
REQ-036 Reset mid-stall: reset=1 asynchronously during MEM_STALL -> outputs 0 immediately, counters 0; after release with no hazard, all load_*=1.
REQ-037 Saturation: preload bubble_count to 16'hFFFE, apply two load-use events -> count reaches 16'hFFFF and holds.
